// File: rtl/ws2811_multi.sv
// Multi-string WS2811/WS2812 driver: CHANNELS strings of NUM_LEDS pixels sent in lock-step,
// with shared bit timing, a latch gap before every frame, and per-frame brightness and channel mask.
module ws2811_multi #(
  parameter int CHANNELS  = 4,
  parameter int NUM_LEDS  = 64,
  parameter int ADDR_W    = 8,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 2500,
  parameter int ORDER     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              brightness,
  input  logic [CHANNELS-1:0]     ch_mask,
  input  logic [8*CHANNELS-1:0]   red_in,
  input  logic [8*CHANNELS-1:0]   green_in,
  input  logic [8*CHANNELS-1:0]   blue_in,
  output logic [ADDR_W-1:0]       address,
  output logic                    busy,
  output logic                    frame_done,
  output logic [CHANNELS-1:0]     DO
);

  localparam int CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0]  T0H        = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0]  T1H        = CNT_W'(T1H_CYC);
  localparam logic [ADDR_W-1:0] PIX_LAST   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'((NUM_LEDS > 1) ? 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cyc_reg;
  logic [4:0]            bit_reg;
  logic [ADDR_W-1:0]     pix_reg;
  logic [ADDR_W-1:0]     address_reg;
  logic                  busy_reg;
  logic                  frame_done_reg;
  logic [7:0]            bright_reg;
  logic [CHANNELS-1:0]   mask_reg;

  logic                  bit_end;
  logic                  pix_end;
  logic                  frame_end;
  logic                  latch_end;
  logic                  start;
  logic                  load_en;
  logic                  shift_en;
  logic [7:0]            bright_sel;
  logic [ADDR_W-1:0]     pix_next;

  // (v * (b + 1)) >> 8 keeps 255 as identity and maps 0 to black.
  function automatic logic [7:0] scale(input logic [7:0] v, input logic [7:0] b);
    return 8'(({8'd0, v} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction

  assign bit_end   = (state_reg == SEND) && (cyc_reg == BIT_LAST);
  assign pix_end   = bit_end && (bit_reg == 5'd0);
  assign frame_end = pix_end && (pix_reg == PIX_LAST);
  assign latch_end = (state_reg == LATCH) && (cyc_reg == LATCH_LAST);
  assign start     = latch_end && enable;
  assign load_en   = start || (pix_end && !frame_end);
  assign shift_en  = bit_end && !pix_end;
  assign pix_next  = pix_reg + ADDR_W'(1);

  // Pixel 0 is loaded while still in LATCH, before bright_reg has captured the new value.
  assign bright_sel = (state_reg == LATCH) ? brightness : bright_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cyc_reg        <= '0;
      bit_reg        <= '0;
      pix_reg        <= '0;
      address_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      bright_reg     <= '0;
      mask_reg       <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cyc_reg <= '0;
          if (enable) begin
            state_reg <= LATCH;
            busy_reg  <= 1'b1;
          end
        end
        LATCH: begin
          if (latch_end) begin
            cyc_reg <= '0;
            if (enable) begin
              state_reg   <= SEND;
              bit_reg     <= 5'd23;
              pix_reg     <= '0;
              bright_reg  <= brightness;
              mask_reg    <= ch_mask;
              address_reg <= FIRST_ADDR;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cyc_reg <= cyc_reg + CNT_W'(1);
          end
        end
        SEND: begin
          if (bit_end) begin
            cyc_reg <= '0;
            if (frame_end) begin
              state_reg      <= LATCH;
              frame_done_reg <= 1'b1;
              address_reg    <= '0;
            end else if (pix_end) begin
              bit_reg     <= 5'd23;
              pix_reg     <= pix_next;
              address_reg <= (pix_next == PIX_LAST) ? PIX_LAST : pix_next + ADDR_W'(1);
            end else begin
              bit_reg <= bit_reg - 5'd1;
            end
          end else begin
            cyc_reg <= cyc_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign address    = address_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [7:0]  r_s;
      logic [7:0]  g_s;
      logic [7:0]  b_s;
      logic [23:0] word_next;
      logic [23:0] sr_reg;
      logic        do_reg;

      assign r_s       = scale(red_in[8*gi +: 8], bright_sel);
      assign g_s       = scale(green_in[8*gi +: 8], bright_sel);
      assign b_s       = scale(blue_in[8*gi +: 8], bright_sel);
      assign word_next = (ORDER == 0) ? {g_s, r_s, b_s} : {r_s, g_s, b_s};

      // Current bit is always sr_reg[23]; the pin follows the shared counter one cycle later.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sr_reg <= '0;
          do_reg <= 1'b0;
        end else begin
          if (load_en) begin
            sr_reg <= word_next;
          end else if (shift_en) begin
            sr_reg <= {sr_reg[22:0], 1'b0};
          end
          do_reg <= (state_reg == SEND) && mask_reg[gi] &&
                    (cyc_reg < (sr_reg[23] ? T1H : T0H));
        end
      end

      assign DO[gi] = do_reg;
    end
  endgenerate

endmodule

// File: tb/tb_ws2811_multi.sv
// Directed bench for ws2811_multi: captures whole frames of DO and decodes the bit cells
// back into colour words, checked against hand-computed values.
module tb_ws2811_multi;

  localparam int MAXN = 512;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  brightness;
  logic [1:0]  ch_mask;
  logic [15:0] red_in;
  logic [15:0] green_in;
  logic [15:0] blue_in;
  logic [3:0]  address;
  logic        busy;
  logic        frame_done;
  logic [1:0]  DO;

  ws2811_multi #(
    .CHANNELS (2),
    .NUM_LEDS (2),
    .ADDR_W   (4),
    .T0H_CYC  (2),
    .T1H_CYC  (5),
    .BIT_CYC  (8),
    .LATCH_CYC(20),
    .ORDER    (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .brightness(brightness),
    .ch_mask   (ch_mask),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .address   (address),
    .busy      (busy),
    .frame_done(frame_done),
    .DO        (DO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // colour tables indexed [channel][pixel]
  logic [7:0] r_tab [2][2];
  logic [7:0] g_tab [2][2];
  logic [7:0] b_tab [2][2];

  always_comb begin
    red_in   = '0;
    green_in = '0;
    blue_in  = '0;
    for (int c = 0; c < 2; c++) begin
      red_in[8*c +: 8]   = r_tab[c][address[0]];
      green_in[8*c +: 8] = g_tab[c][address[0]];
      blue_in[8*c +: 8]  = b_tab[c][address[0]];
    end
  end

  logic [1:0] do_s   [MAXN];
  logic       fd_s   [MAXN];
  logic [3:0] addr_s [MAXN];
  logic       busy_s [MAXN];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // sample i is taken on the negedge after the (i+1)-th posedge following the call
  task automatic capture(input int n, input int drop_at, input int chg_at, input logic [1:0] chg_mask);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      do_s[i]   = DO;
      fd_s[i]   = frame_done;
      addr_s[i] = address;
      busy_s[i] = busy;
      if (i == drop_at) enable = 1'b0;
      if (i == chg_at) ch_mask = chg_mask;
    end
  endtask

  function automatic int count_high(input int lo, input int hi, input int ch);
    int cnt = 0;
    for (int i = lo; i <= hi; i++) cnt += int'(do_s[i][ch]);
    return cnt;
  endfunction

  function automatic int count_fd(input int lo, input int hi);
    int cnt = 0;
    for (int i = lo; i <= hi; i++) cnt += int'(fd_s[i]);
    return cnt;
  endfunction

  // returns the posedge number (1-based) after which DO[ch] was first seen high
  function automatic int first_rise(input int n, input int ch);
    for (int i = 0; i < n; i++) begin
      if (do_s[i][ch]) return i + 1;
    end
    return -1;
  endfunction

  // each bit cell is 8 samples; a valid cell is a high prefix of 2 or 5 samples
  task automatic decode(input int base, input int ch, input int pix, output logic [23:0] word, output int bad);
    bad  = 0;
    word = '0;
    for (int b = 0; b < 24; b++) begin
      int cnt;
      logic seen_low;
      cnt = 0;
      seen_low = 1'b0;
      for (int k = 0; k < 8; k++) begin
        logic s;
        s = do_s[base + pix*192 + b*8 + k][ch];
        if (s && seen_low) bad++;
        if (!s) seen_low = 1'b1;
        cnt += int'(s);
      end
      word[23-b] = (cnt == 5);
      if (cnt != 2 && cnt != 5) bad++;
    end
  endtask

  task automatic check_words(input string pfx, input int ch, input logic [23:0] e0, input logic [23:0] e1);
    logic [23:0] w;
    int bad0;
    int bad1;
    decode(21, ch, 0, w, bad0);
    check_eq({pfx, "_p0"}, 32'(w), 32'(e0));
    decode(21, ch, 1, w, bad1);
    check_eq({pfx, "_p1"}, 32'(w), 32'(e1));
    check_eq({pfx, "_badcells"}, bad0 + bad1, 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    r_tab[0][0] = 8'hFF; g_tab[0][0] = 8'h00; b_tab[0][0] = 8'h81;
    r_tab[1][0] = 8'h12; g_tab[1][0] = 8'h34; b_tab[1][0] = 8'h56;
    r_tab[0][1] = 8'h0A; g_tab[0][1] = 8'hB0; b_tab[0][1] = 8'hC3;
    r_tab[1][1] = 8'h01; g_tab[1][1] = 8'h80; b_tab[1][1] = 8'h7E;

    reset      = 1'b1;
    enable     = 1'b0;
    brightness = 8'hFF;
    ch_mask    = 2'b11;
    repeat (3) @(negedge clk);
    check_eq("rst_do", 32'(DO), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(address), 32'd0);
    check_eq("rst_fd", 32'(frame_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // full brightness, both channels; enable dropped in pixel 0, mask changed mid-frame
    $display("frame A: brightness ff mask 11");
    enable = 1'b1;
    capture(440, 50, 60, 2'b01);
    check_eq("A_first_rise", first_rise(440, 0), 22);
    check_eq("A_busy_start", 32'(busy_s[0]), 32'd1);
    check_eq("A_addr_latch", 32'(addr_s[19]), 32'd0);
    check_eq("A_addr_start", 32'(addr_s[20]), 32'd1);
    check_eq("A_addr_last", 32'(addr_s[403]), 32'd1);
    check_eq("A_addr_end", 32'(addr_s[404]), 32'd0);
    check_eq("A_fd_at_end", 32'(fd_s[404]), 32'd1);
    check_eq("A_fd_count", count_fd(0, 439), 1);
    check_words("A_ch0", 0, 24'h00FF81, 24'hB00AC3);
    check_words("A_ch1", 1, 24'h341256, 24'h80017E);
    check_eq("A_busy_gap_end", 32'(busy_s[423]), 32'd1);
    check_eq("A_busy_idle", 32'(busy_s[424]), 32'd0);
    check_eq("A_do_quiet", count_high(404, 439, 0) + count_high(404, 439, 1), 0);
    wait_idle("A_idle");

    $display("frame B: brightness ff mask 01");
    enable = 1'b1;
    capture(440, 30, -1, 2'b00);
    check_eq("B_ch1_quiet", count_high(0, 439, 1), 0);
    check_words("B_ch0", 0, 24'h00FF81, 24'hB00AC3);
    wait_idle("B_idle");

    $display("frame C: brightness 7f mask 11");
    ch_mask    = 2'b11;
    brightness = 8'h7F;
    enable     = 1'b1;
    capture(440, 30, -1, 2'b00);
    check_words("C_ch0", 0, 24'h007F40, 24'h580561);
    check_words("C_ch1", 1, 24'h1A092B, 24'h40003F);
    wait_idle("C_idle");

    $display("frame D: brightness 00 mask 11");
    brightness = 8'h00;
    enable     = 1'b1;
    capture(440, 30, -1, 2'b00);
    check_words("D_ch0", 0, 24'h000000, 24'h000000);
    check_words("D_ch1", 1, 24'h000000, 24'h000000);
    wait_idle("D_idle");

    $display("E: asynchronous reset while DO high");
    brightness = 8'hFF;
    enable     = 1'b1;
    for (int i = 0; i < 100 && !DO[0]; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("E_pre_rst_do", 32'(DO[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("E_rst_do", 32'(DO), 32'd0);
    check_eq("E_rst_busy", 32'(busy), 32'd0);
    check_eq("E_rst_addr", 32'(address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    capture(40, -1, -1, 2'b00);
    check_eq("E_first_rise", first_rise(40, 0), 22);
    check_eq("E_busy", 32'(busy_s[0]), 32'd1);
    check_eq("E_addr_latch", 32'(addr_s[19]), 32'd0);
    check_eq("E_addr_start", 32'(addr_s[20]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
